// File: rtl/fir_lowpass.sv
// Single-MAC, time-multiplexed FIR low-pass filter: one 16-bit Q1.15 output per accepted input.
// Coefficients sit in a writable register bank that is frozen while a convolution runs.
module fir_lowpass #(
    parameter int NTAPS = 32,
    parameter int ACC_W = 40,
    localparam int AW   = $clog2(NTAPS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic signed [15:0]  in_sample_i,
    input  logic                in_valid_i,
    input  logic                coef_we_i,
    input  logic [AW-1:0]       coef_addr_i,
    input  logic signed [15:0]  coef_data_i,
    output logic signed [15:0]  out_sample_o,
    output logic                out_valid_o,
    output logic                busy_o,
    output logic                overrun_o,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        RND  = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(16384);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-32768);

    state_t                    state_q;
    logic [AW-1:0]             wp_q;
    logic [AW-1:0]             base_q;
    logic [AW-1:0]             k_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [15:0]        x_q [NTAPS];
    logic signed [15:0]        h_q [NTAPS];
    logic signed [15:0]        out_sample_q;
    logic                      out_valid_q;
    logic                      overrun_q;

    logic [AW-1:0]             tap_idx;
    logic signed [31:0]        prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   rounded;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [15:0]        sat_d;

    // NTAPS is a power of two, so the subtraction wraps modulo NTAPS for free.
    always_comb begin
        tap_idx  = base_q - k_q;
        prod     = h_q[k_q] * x_q[tap_idx];
        prod_ext = {{(ACC_W-32){prod[31]}}, prod};
        rounded  = acc_q + RND_BIAS;
        shifted  = rounded >>> 15;
        if (shifted > SAT_MAX) begin
            sat_d = 16'sh7FFF;
        end else if (shifted < SAT_MIN) begin
            sat_d = -16'sh8000;
        end else begin
            sat_d = shifted[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wp_q         <= '0;
            base_q       <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                x_q[i] <= '0;
                h_q[i] <= (i == 0) ? 16'sh7FFF : 16'sh0000;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A coefficient written alongside in_valid is used by this convolution.
                    if (coef_we_i) begin
                        h_q[coef_addr_i] <= coef_data_i;
                    end
                    if (in_valid_i) begin
                        x_q[wp_q] <= in_sample_i;
                        base_q    <= wp_q;
                        wp_q      <= wp_q + AW'(1);
                        acc_q     <= '0;
                        k_q       <= '0;
                        state_q   <= MAC;
                    end
                end
                MAC: begin
                    if (in_valid_i) begin
                        overrun_q <= 1'b1;
                    end
                    acc_q <= acc_q + prod_ext;
                    k_q   <= k_q + AW'(1);
                    if (k_q == AW'(NTAPS - 1)) begin
                        state_q <= RND;
                    end
                end
                RND: begin
                    if (in_valid_i) begin
                        overrun_q <= 1'b1;
                    end
                    out_sample_q <= sat_d;
                    out_valid_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_sample_o = out_sample_q;
    assign out_valid_o  = out_valid_q;
    assign busy_o       = (state_q != IDLE);
    assign overrun_o    = overrun_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_fir_lowpass.sv
// Directed bench for fir_lowpass: hand-computed outputs for passthrough, impulse,
// saturation, overrun, frozen coefficients and mid-convolution reset.
module tb_fir_lowpass;

    localparam int NTAPS = 32;
    localparam int AW    = 5;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [15:0] in_sample = '0;
    logic               in_valid = 1'b0;
    logic               coef_we = 1'b0;
    logic [AW-1:0]      coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic signed [15:0] out_sample;
    logic               out_valid;
    logic               busy;
    logic               overrun;
    logic [1:0]         state;

    int checks = 0;
    int errors = 0;

    fir_lowpass #(.NTAPS(NTAPS), .ACC_W(40)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_sample_i  (in_sample),
        .in_valid_i   (in_valid),
        .coef_we_i    (coef_we),
        .coef_addr_i  (coef_addr),
        .coef_data_i  (coef_data),
        .out_sample_o (out_sample),
        .out_valid_o  (out_valid),
        .busy_o       (busy),
        .overrun_o    (overrun),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        reset_n  = 1'b0;
        tick();
        tick();
        reset_n  = 1'b1;
        tick();
    endtask

    task automatic write_coef(input logic [AW-1:0] addr, input logic signed [15:0] data);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic write_all(input logic signed [15:0] data);
        for (int i = 0; i < NTAPS; i++) begin
            write_coef(AW'(i), data);
        end
    endtask

    // Feed one sample in IDLE and wait for its output; latency counted in cycles.
    task automatic run_sample(input logic signed [15:0] s, input logic signed [15:0] exp, input string tag);
        int n;
        bit seen;
        seen      = 1'b0;
        in_sample = s;
        in_valid  = 1'b1;
        for (n = 1; n <= 100; n++) begin
            tick();
            if (n == 1) begin
                in_valid = 1'b0;
                coef_we  = 1'b0;
                check({tag, "_busy"}, busy, 1);
            end
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_lat"}, seen ? n : -1, 34);
        check({tag, "_out"}, out_sample, exp);
        check({tag, "_idle"}, busy, 0);
        tick();
        check({tag, "_pulse"}, out_valid, 0);
    endtask

    initial begin
        int pulses;
        logic signed [15:0] got;

        // Reset defaults
        tick();
        check("rst_ov", out_valid, 0);
        check("rst_os", out_sample, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        reset_n = 1'b1;
        tick();
        check("rel_ov", out_valid, 0);
        run_sample(16'sd1000, 16'sd1000, "dflt");
        check("dflt_hold", out_sample, 1000);

        // Coefficient write on the same edge as in_valid: 1000*0x4000 -> 500
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = 16'sh4000;
        run_sample(16'sd1000, 16'sd500, "simul");

        // Impulse response with four taps of 0.5
        do_reset();
        write_all(16'sh0000);
        for (int i = 0; i < 4; i++) write_coef(AW'(i), 16'sh4000);
        run_sample(16'sh7FFF, 16'sd16384, "imp0");
        run_sample(16'sd0, 16'sd16384, "imp1");
        run_sample(16'sd0, 16'sd16384, "imp2");
        run_sample(16'sd0, 16'sd16384, "imp3");
        run_sample(16'sd0, 16'sd0, "imp4");

        // Positive saturation
        do_reset();
        write_all(16'sh7FFF);
        run_sample(16'sh7FFF, 16'sd32766, "satp0");
        run_sample(16'sh7FFF, 16'sd32767, "satp1");
        run_sample(16'sh7FFF, 16'sd32767, "satp2");

        // Negative saturation
        do_reset();
        write_all(16'sh7FFF);
        run_sample(-16'sd32768, -16'sd32767, "satn0");
        run_sample(-16'sd32768, -16'sd32768, "satn1");
        run_sample(-16'sd32768, -16'sd32768, "satn2");

        // Overrun: output equals previous accepted sample (h[1] only)
        do_reset();
        write_coef(0, 16'sh0000);
        write_coef(1, 16'sh7FFF);
        check("ovr_pre", overrun, 0);
        pulses    = 0;
        got       = 16'sh7777;
        in_sample = 16'sd1000;
        in_valid  = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == 1) in_valid = 1'b0;
            if (n == 5) begin
                in_sample = 16'sd2000;
                in_valid  = 1'b1;
            end
            if (n == 6) in_valid = 1'b0;
            if (out_valid) begin
                pulses++;
                got = out_sample;
            end
        end
        check("ovr_pulses", pulses, 1);
        check("ovr_out", got, 0);
        check("ovr_flag", overrun, 1);
        run_sample(16'sd3000, 16'sd1000, "ovr_dl");
        check("ovr_sticky", overrun, 1);

        // Coefficient write during MAC is ignored
        do_reset();
        pulses    = 0;
        got       = 16'sh7777;
        in_sample = 16'sd500;
        in_valid  = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) in_valid = 1'b0;
            if (n == 5) begin
                coef_we   = 1'b1;
                coef_addr = '0;
                coef_data = 16'sh0000;
            end
            if (n == 6) coef_we = 1'b0;
            if (out_valid) begin
                pulses++;
                got = out_sample;
            end
        end
        check("cwb_pulses", pulses, 1);
        check("cwb_first", got, 500);
        run_sample(16'sd1000, 16'sd1000, "cwb");

        // Reset in the middle of MAC
        do_reset();
        write_coef(0, 16'sh2000);
        write_coef(1, 16'sh7FFF);
        in_sample = 16'sd1000;
        in_valid  = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 1) in_valid = 1'b0;
        end
        check("mid_busy_pre", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_state", state, 0);
        check("mid_ov", out_valid, 0);
        tick();
        tick();
        reset_n = 1'b1;
        pulses  = 0;
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (out_valid) pulses++;
        end
        check("mid_nopulse", pulses, 0);
        check("mid_os", out_sample, 0);
        run_sample(16'sd1000, 16'sd1000, "mid_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_lowpass.md
# fir_lowpass

Time-multiplexed, single-MAC FIR low-pass filter. It takes 16-bit PCM samples at the 16 kHz audio rate and produces one filtered 16-bit sample per input. It sits directly upstream of the SPI audio transmitter, and its out_sample/out_valid pair drives that block's audio_sample/sample_valid. Coefficients live in a register bank with a write port, so firmware or the testbench can reload the response.

## Interface
- NTAPS, 32: number of taps, must be ≥2, power of two.
- ACC_W, 40: accumulator width, must be ≥32+log2(NTAPS).
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- in_sample  in  16  signed PCM input, Q1.15.
- in_valid  in  1  one-cycle strobe; in_sample is valid in that cycle.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  log2(NTAPS)  coefficient index k.
- coef_data  in  16  signed coefficient h[k], Q1.15.
- out_sample  out  16  signed filtered sample; held between updates.
- out_valid  out  1  one-cycle strobe marking a new out_sample.
- busy  out  1  high while a convolution is in progress.
- overrun  out  1  sticky flag: an input was dropped because busy was high.

## Operation
- Storage:
  - Delay line: NTAPS×16-bit circular buffer with write pointer wp.
  - Coefficient bank: NTAPS×16-bit registers h[0..NTAPS-1].
- FSM states: IDLE, MAC, RND.
- IDLE:
  - On in_valid, write in_sample to x[wp], clear acc, set k=0, go to MAC.
  - The pointer is called base = wp at this moment; wp increments modulo NTAPS and wraps from NTAPS-1 to 0.
- MAC:
  - Each cycle: acc += h[k] × x[(base − k) mod NTAPS].
  - The product is a 32-bit signed value, sign-extended to ACC_W.
  - k increments each cycle; after k=NTAPS-1, go to RND.
- RND:
  - r = (acc + 2^14) >>> 15, arithmetic shift.
  - Saturate r to [−32768, 32767] and register it into out_sample.
  - Go to IDLE and pulse out_valid for the next cycle.
- busy = (state ≠ IDLE).
- in_valid while busy: the sample is dropped, the delay line and wp are unchanged, overrun is set to 1. overrun clears only on reset.
- coef_we while in IDLE: h[coef_addr] ← coef_data on that edge.
- coef_we while busy: the write is ignored, so coefficients never change mid-convolution.
- Simultaneous in_valid and coef_we in IDLE: both happen. The new coefficient is written on the same edge and is used by the convolution that starts there.
- Reset, asynchronous and valid at any time including mid-MAC:
  - State → IDLE; wp, k, acc → 0; delay line → all 0.
  - h[0] → 0x7FFF and h[1..] → 0, giving near-passthrough.
  - out_sample → 0, out_valid → 0, busy → 0, overrun → 0.
  - No out_valid is produced for an interrupted convolution.

## Timing
- Cycle T: in_valid accepted in IDLE.
- Cycles T+1 … T+NTAPS: MAC, busy=1.
- Cycle T+NTAPS+1: RND, busy=1.
- Cycle T+NTAPS+2: out_valid=1, out_sample updated, busy=0.
- Latency is NTAPS+2 cycles (34 at default).
- An in_valid in cycle T+NTAPS+2 is accepted. The minimum input spacing is NTAPS+2 cycles, far below the 16 kHz period at any supported clk.
- out_valid is exactly one cycle wide.
- out_sample changes only at the edge that raises out_valid.

## Test plan
- Reset defaults: release reset, then in_valid with in_sample=1000 → out_valid exactly 34 cycles later with out_sample=1000; all outputs 0 before that.
- Impulse response:
  - Stimulus: write h[0..3]=0x4000 and h[4..31]=0, then feed 0x7FFF followed by zeros, spaced 40 cycles apart.
  - Required: outputs 16384, 16384, 16384, 16384, then 0.
- Saturation:
  - Set all h[k]=0x7FFF, then feed 0x7FFF repeatedly: outputs 32766, then 32767 saturated thereafter.
  - Feed −32768 repeatedly with the same coefficients: outputs −32767 first, then −32768.
- Overrun: second in_valid 5 cycles after an accepted one → only one out_valid, overrun=1 and stays high; delay-line contents are unchanged, checked by a subsequent impulse.
- Coefficient write while busy:
  - Stimulus: with the default coefficients (h[0]=0x7FFF, h[1..31]=0), write h[0]=0 during MAC, then feed 1000.
  - Required: the next output still equals 1000.
- Reset mid-MAC: assert reset_n=0 at cycle T+10 → busy=0 immediately, no out_valid ever; the next input of 1000 yields 1000, confirming the delay line is cleared and default coefficients are restored.
